lcd_arbiter: RTL and testbench

//  Shares the single character-LCD write port between two client controllers (e.g. BER display, status display).

---
 rtl/lcd_arbiter.sv | 166 ++++++++++++++++
 tb/tb_lcd_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_arbiter.sv
// Round-robin, burst-granular arbiter sharing one character-LCD write port between two clients.
// Owner writes are forwarded registered one cycle late; an optional hold limit revokes long grants.
module lcd_arbiter #(
    parameter logic [31:0] MAX_HOLD = 32'd0
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       c0_req,
    input  logic       c0_we,
    input  logic       c0_row,
    input  logic [3:0] c0_col,
    input  logic [7:0] c0_char,
    output logic       c0_gnt,
    output logic       c0_busy,
    input  logic       c1_req,
    input  logic       c1_we,
    input  logic       c1_row,
    input  logic [3:0] c1_col,
    input  logic [7:0] c1_char,
    output logic       c1_gnt,
    output logic       c1_busy,
    output logic       lcd_row,
    output logic [3:0] lcd_col,
    output logic [7:0] lcd_char,
    output logic       lcd_we,
    input  logic       lcd_busy,
    output logic       preempt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN0  = 2'd1,
        OWN1  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic        last_reg, last_next;
    logic [31:0] hold_cnt_reg, hold_cnt_next;
    logic        preempt_reg, preempt_next;
    logic        lcd_we_reg;
    logic        lcd_row_reg;
    logic [3:0]  lcd_col_reg;
    logic [7:0]  lcd_char_reg;

    logic [1:0]  req;
    logic [1:0]  we;
    logic [1:0]  row_in;
    logic [3:0]  col_in  [2];
    logic [7:0]  char_in [2];
    logic [1:0]  gnt;
    logic [1:0]  busy;

    logic        owning;
    logic        own_idx;
    logic        accept;
    logic        other_req;
    logic        hold_limit;

    assign req        = {c1_req, c0_req};
    assign we         = {c1_we, c0_we};
    assign row_in     = {c1_row, c0_row};
    assign col_in[0]  = c0_col;
    assign col_in[1]  = c1_col;
    assign char_in[0] = c0_char;
    assign char_in[1] = c1_char;

    assign owning  = (state_reg == OWN0) || (state_reg == OWN1);
    assign own_idx = (state_reg == OWN1);

    // A client may write only while it owns the port and the driver path is idle.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_client
            assign gnt[gi]  = owning && (own_idx == 1'(gi));
            assign busy[gi] = ~gnt[gi] | lcd_busy | lcd_we_reg;
        end
    endgenerate

    assign c0_gnt  = gnt[0];
    assign c1_gnt  = gnt[1];
    assign c0_busy = busy[0];
    assign c1_busy = busy[1];

    assign accept     = owning && we[own_idx] && !busy[own_idx];
    assign other_req  = req[~own_idx];
    // >= rather than == so a limit reached during an accepted write still fires next idle cycle.
    assign hold_limit = (MAX_HOLD != 32'd0) && (hold_cnt_reg >= (MAX_HOLD - 32'd1));

    always_comb begin
        state_next    = state_reg;
        last_next     = last_reg;
        hold_cnt_next = hold_cnt_reg;
        preempt_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                hold_cnt_next = 32'd0;
                if (req[0] && req[1]) begin
                    // last==1 means client 1 was served last, so client 0 wins the tie.
                    state_next = last_reg ? OWN0 : OWN1;
                    last_next  = ~last_reg;
                end else if (req[0]) begin
                    state_next = OWN0;
                    last_next  = 1'b0;
                end else if (req[1]) begin
                    state_next = OWN1;
                    last_next  = 1'b1;
                end
            end
            OWN0, OWN1: begin
                if (!req[own_idx]) begin
                    state_next    = DRAIN;
                    hold_cnt_next = 32'd0;
                end else if (hold_limit && other_req && !accept) begin
                    state_next    = DRAIN;
                    preempt_next  = 1'b1;
                    hold_cnt_next = 32'd0;
                end else if (other_req) begin
                    if (hold_cnt_reg != 32'hFFFF_FFFF) begin
                        hold_cnt_next = hold_cnt_reg + 32'd1;
                    end
                end else begin
                    hold_cnt_next = 32'd0;
                end
            end
            DRAIN: begin
                if (!lcd_we_reg && !lcd_busy) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg    <= IDLE;
            last_reg     <= 1'b1;
            hold_cnt_reg <= 32'd0;
            preempt_reg  <= 1'b0;
            lcd_we_reg   <= 1'b0;
            lcd_row_reg  <= 1'b0;
            lcd_col_reg  <= 4'd0;
            lcd_char_reg <= 8'd0;
        end else begin
            state_reg    <= state_next;
            last_reg     <= last_next;
            hold_cnt_reg <= hold_cnt_next;
            preempt_reg  <= preempt_next;
            lcd_we_reg   <= accept;
            if (accept) begin
                lcd_row_reg  <= row_in[own_idx];
                lcd_col_reg  <= col_in[own_idx];
                lcd_char_reg <= char_in[own_idx];
            end
        end
    end

    assign lcd_we   = lcd_we_reg;
    assign lcd_row  = lcd_row_reg;
    assign lcd_col  = lcd_col_reg;
    assign lcd_char = lcd_char_reg;
    assign preempt  = preempt_reg;

endmodule

// File: tb/tb_lcd_arbiter.sv
// Bench for lcd_arbiter: two instances (unlimited hold and MAX_HOLD=8) on shared stimulus,
// checked every cycle against a transaction-level model plus directed literal expectations.
module tb_lcd_arbiter;

    logic       CLK = 1'b0;
    logic       RST;
    logic       c0_req, c0_we, c0_row, c1_req, c1_we, c1_row;
    logic [3:0] c0_col, c1_col;
    logic [7:0] c0_char, c1_char;
    logic       lcd_busy;
    logic       busy_mode, busy_force, drv_busy;
    int         drv_cnt;
    logic       we_seen;

    logic       u_c0_gnt, u_c0_busy, u_c1_gnt, u_c1_busy, u_lcd_row, u_lcd_we, u_preempt;
    logic [3:0] u_lcd_col;
    logic [7:0] u_lcd_char;
    logic       h_c0_gnt, h_c0_busy, h_c1_gnt, h_c1_busy, h_lcd_row, h_lcd_we, h_preempt;
    logic [3:0] h_lcd_col;
    logic [7:0] h_lcd_char;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    assign lcd_busy = busy_mode ? drv_busy : busy_force;

    lcd_arbiter #(.MAX_HOLD(32'd0)) dut_u (
        .CLK(CLK), .RST(RST),
        .c0_req(c0_req), .c0_we(c0_we), .c0_row(c0_row), .c0_col(c0_col), .c0_char(c0_char),
        .c0_gnt(u_c0_gnt), .c0_busy(u_c0_busy),
        .c1_req(c1_req), .c1_we(c1_we), .c1_row(c1_row), .c1_col(c1_col), .c1_char(c1_char),
        .c1_gnt(u_c1_gnt), .c1_busy(u_c1_busy),
        .lcd_row(u_lcd_row), .lcd_col(u_lcd_col), .lcd_char(u_lcd_char), .lcd_we(u_lcd_we),
        .lcd_busy(lcd_busy), .preempt(u_preempt)
    );

    lcd_arbiter #(.MAX_HOLD(32'd8)) dut_h (
        .CLK(CLK), .RST(RST),
        .c0_req(c0_req), .c0_we(c0_we), .c0_row(c0_row), .c0_col(c0_col), .c0_char(c0_char),
        .c0_gnt(h_c0_gnt), .c0_busy(h_c0_busy),
        .c1_req(c1_req), .c1_we(c1_we), .c1_row(c1_row), .c1_col(c1_col), .c1_char(c1_char),
        .c1_gnt(h_c1_gnt), .c1_busy(h_c1_busy),
        .lcd_row(h_lcd_row), .lcd_col(h_lcd_col), .lcd_char(h_lcd_char), .lcd_we(h_lcd_we),
        .lcd_busy(lcd_busy), .preempt(h_preempt)
    );

    // Model: who owns the port (-1 none), whether we wait for the driver, and the pending write.
    typedef struct {
        int          owner;
        bit          drain;
        bit          last;
        longint      hold;
        bit          we;
        logic        row;
        logic [3:0]  col;
        logic [7:0]  chr;
        bit          pre;
    } mstate_t;

    mstate_t ms [2];
    bit      mvalid = 1'b0;
    logic [12:0] wq [$];

    function automatic mstate_t mstep(mstate_t s, longint mh, logic rst, logic [1:0] req,
                                      logic [1:0] wr, logic [12:0] d0, logic [12:0] d1, logic lb);
        mstate_t n = s;
        bit acc = 1'b0;
        int o;
        n.pre = 1'b0;
        if (rst) begin
            n.owner = -1; n.drain = 1'b0; n.last = 1'b1; n.hold = 0;
            n.we = 1'b0; n.row = 1'b0; n.col = 4'd0; n.chr = 8'd0;
            return n;
        end
        if (s.owner >= 0) begin
            o = s.owner;
            acc = (wr[o] == 1'b1) && !(lb || s.we);
            if (acc) {n.row, n.col, n.chr} = (o == 0) ? d0 : d1;
            if (req[o] == 1'b0) begin
                n.owner = -1; n.drain = 1'b1; n.hold = 0;
            end else if (mh != 0 && req[1-o] == 1'b1 && s.hold >= mh - 1 && !acc) begin
                n.owner = -1; n.drain = 1'b1; n.pre = 1'b1; n.hold = 0;
            end else if (req[1-o] == 1'b1) begin
                n.hold = (s.hold < 64'hFFFF_FFFF) ? s.hold + 1 : s.hold;
            end else begin
                n.hold = 0;
            end
        end else if (s.drain) begin
            if (!s.we && lb == 1'b0) n.drain = 1'b0;
        end else begin
            if (req == 2'b11) n.owner = s.last ? 0 : 1;
            else if (req[0] == 1'b1) n.owner = 0;
            else if (req[1] == 1'b1) n.owner = 1;
            if (n.owner >= 0) n.last = n.owner[0];
            n.hold = 0;
        end
        n.we = acc;
        return n;
    endfunction

    always @(posedge CLK) begin
        ms[0] <= mstep(ms[0], 0, RST, {c1_req, c0_req}, {c1_we, c0_we},
                       {c0_row, c0_col, c0_char}, {c1_row, c1_col, c1_char}, lcd_busy);
        ms[1] <= mstep(ms[1], 8, RST, {c1_req, c0_req}, {c1_we, c0_we},
                       {c0_row, c0_col, c0_char}, {c1_row, c1_col, c1_char}, lcd_busy);
        if (RST) mvalid <= 1'b1;
    end

    // LCD driver emulation: busy for 3 cycles, starting the cycle after each dut_u write.
    always @(posedge CLK) begin
        #1;
        if (we_seen) begin
            drv_cnt  <= 2;
            drv_busy <= 1'b1;
        end else begin
            drv_busy <= (drv_cnt != 0);
            if (drv_cnt != 0) drv_cnt <= drv_cnt - 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_dut(input string tag, input mstate_t s,
                             input logic g0, input logic b0, input logic g1, input logic b1,
                             input logic row, input logic [3:0] col, input logic [7:0] chr,
                             input logic wr, input logic pre);
        chk({tag, ".c0_gnt"},   32'(g0),  32'(s.owner == 0));
        chk({tag, ".c1_gnt"},   32'(g1),  32'(s.owner == 1));
        chk({tag, ".c0_busy"},  32'(b0),  32'((s.owner != 0) || lcd_busy || s.we));
        chk({tag, ".c1_busy"},  32'(b1),  32'((s.owner != 1) || lcd_busy || s.we));
        chk({tag, ".lcd_we"},   32'(wr),  32'(s.we));
        chk({tag, ".lcd_row"},  32'(row), 32'(s.row));
        chk({tag, ".lcd_col"},  32'(col), 32'(s.col));
        chk({tag, ".lcd_char"}, 32'(chr), 32'(s.chr));
        chk({tag, ".preempt"},  32'(pre), 32'(s.pre));
    endtask

    always @(negedge CLK) begin
        we_seen <= (u_lcd_we === 1'b1);
        if (mvalid) begin
            check_dut("u", ms[0], u_c0_gnt, u_c0_busy, u_c1_gnt, u_c1_busy,
                      u_lcd_row, u_lcd_col, u_lcd_char, u_lcd_we, u_preempt);
            check_dut("h", ms[1], h_c0_gnt, h_c0_busy, h_c1_gnt, h_c1_busy,
                      h_lcd_row, h_lcd_col, h_lcd_char, h_lcd_we, h_preempt);
            if (u_lcd_we === 1'b1) begin
                wq.push_back({u_lcd_row, u_lcd_col, u_lcd_char});
                $display("lcd write: row=%0d col=%0d char=%02h t=%0t", u_lcd_row, u_lcd_col, u_lcd_char, $time);
            end
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #2;
    endtask

    task automatic reset_dut();
        RST = 1'b1;
        c0_req = 1'b0; c0_we = 1'b0; c1_req = 1'b0; c1_we = 1'b0;
        busy_force = 1'b0;
        cyc();
        cyc();
        RST = 1'b0;
    endtask

    initial begin
        int n;
        int w;
        int base;
        bit c1_seen;
        RST = 1'b1;
        c0_req = 1'b0; c0_we = 1'b0; c0_row = 1'b0; c0_col = 4'd0; c0_char = 8'd0;
        c1_req = 1'b0; c1_we = 1'b0; c1_row = 1'b0; c1_col = 4'd0; c1_char = 8'd0;
        busy_mode = 1'b0; busy_force = 1'b0; drv_busy = 1'b0; drv_cnt = 0; we_seen = 1'b0;

        // Reset values and grant latency; first write forwarded one cycle late.
        reset_dut();
        chk("rst_c0_gnt", 32'(u_c0_gnt), 32'd0);
        chk("rst_c1_gnt", 32'(u_c1_gnt), 32'd0);
        chk("rst_lcd_we", 32'(u_lcd_we), 32'd0);
        chk("rst_lcd_char", 32'(u_lcd_char), 32'd0);
        chk("rst_preempt", 32'(h_preempt), 32'd0);
        c0_req = 1'b1;
        cyc();
        chk("t1_c0_gnt", 32'(u_c0_gnt), 32'd1);
        chk("t1_c0_busy", 32'(u_c0_busy), 32'd0);
        c0_we = 1'b1; c0_row = 1'b0; c0_col = 4'd3; c0_char = 8'h41;
        cyc();
        chk("t1_lcd_we", 32'(u_lcd_we), 32'd1);
        chk("t1_lcd_col", 32'(u_lcd_col), 32'd3);
        chk("t1_lcd_char", 32'(u_lcd_char), 32'h41);
        chk("t1_c0_busy_after", 32'(u_c0_busy), 32'd1);
        c0_we = 1'b0;
        cyc();
        chk("t1_we_pulse", 32'(u_lcd_we), 32'd0);
        chk("t1_col_hold", 32'(u_lcd_col), 32'd3);

        // Non-owner writes are ignored; busy blocks repeated writes.
        c1_we = 1'b1; c1_col = 4'd9; c1_char = 8'h99;
        cyc();
        chk("t3_nonowner_we", 32'(u_lcd_we), 32'd0);
        cyc();
        chk("t3_nonowner_char", 32'(u_lcd_char), 32'h41);
        c1_we = 1'b0;
        c0_we = 1'b1; c0_col = 4'd5; c0_char = 8'h42;
        n = 0;
        cyc();
        if (u_lcd_we === 1'b1) n++;
        busy_force = 1'b1;
        repeat (7) begin
            cyc();
            if (u_lcd_we === 1'b1) n++;
        end
        chk("t3_one_write", 32'(n), 32'd1);
        c0_char = 8'h43;
        busy_force = 1'b0;
        cyc();
        chk("t3_next_write", 32'(u_lcd_we), 32'd1);
        chk("t3_next_char", 32'(u_lcd_char), 32'h43);
        c0_we = 1'b0; c0_req = 1'b0;
        repeat (4) cyc();

        // Simultaneous requests: c0 first, drain on lcd_busy, then round-robin.
        reset_dut();
        c0_req = 1'b1; c1_req = 1'b1;
        cyc();
        chk("t2_c0_first", 32'(u_c0_gnt), 32'd1);
        chk("t2_c1_wait", 32'(u_c1_gnt), 32'd0);
        c0_req = 1'b0; busy_force = 1'b1;
        cyc();
        chk("t2_c0_release", 32'(u_c0_gnt), 32'd0);
        cyc();
        cyc();
        chk("t2_drain_hold", 32'(u_c1_gnt), 32'd0);
        busy_force = 1'b0;
        cyc();
        chk("t2_idle_gap", 32'(u_c1_gnt), 32'd0);
        cyc();
        chk("t2_c1_gnt", 32'(u_c1_gnt), 32'd1);
        c1_req = 1'b0;
        cyc();
        cyc();
        c0_req = 1'b1; c1_req = 1'b1;
        cyc();
        chk("t2_rr_c0", 32'(u_c0_gnt), 32'd1);
        chk("t2_rr_c1", 32'(u_c1_gnt), 32'd0);
        c0_req = 1'b0; c1_req = 1'b0;
        repeat (4) cyc();

        // Hold limit on the MAX_HOLD=8 instance.
        reset_dut();
        c0_req = 1'b1;
        repeat (3) cyc();
        c1_req = 1'b1;
        for (int i = 1; i < 8; i++) begin
            cyc();
            chk("t4_still_owned", 32'(h_c0_gnt), 32'd1);
            chk("t4_no_preempt", 32'(h_preempt), 32'd0);
        end
        cyc();
        chk("t4_revoked", 32'(h_c0_gnt), 32'd0);
        chk("t4_preempt", 32'(h_preempt), 32'd1);
        chk("t4_unlimited_keeps", 32'(u_c0_gnt), 32'd1);
        cyc();
        chk("t4_preempt_pulse", 32'(h_preempt), 32'd0);
        chk("t4_gap", 32'(h_c1_gnt), 32'd0);
        cyc();
        chk("t4_c1_wins", 32'(h_c1_gnt), 32'd1);
        chk("t4_c0_out", 32'(h_c0_gnt), 32'd0);
        c0_req = 1'b0; c1_req = 1'b0;
        repeat (4) cyc();

        // Reset on the cycle a write is accepted drops the write.
        reset_dut();
        c0_req = 1'b1;
        cyc();
        c0_we = 1'b1; c0_char = 8'h55; RST = 1'b1;
        cyc();
        chk("t5_we_dropped", 32'(u_lcd_we), 32'd0);
        chk("t5_c0_gnt", 32'(u_c0_gnt), 32'd0);
        chk("t5_c1_gnt", 32'(u_c1_gnt), 32'd0);
        chk("t5_char", 32'(u_lcd_char), 32'd0);
        RST = 1'b0; c0_we = 1'b0;
        cyc();
        chk("t5_regrant", 32'(u_c0_gnt), 32'd1);
        c0_req = 1'b0;
        repeat (4) cyc();

        // 16-char burst with driver busy after each write, c1 requesting throughout.
        reset_dut();
        busy_mode = 1'b1;
        c0_req = 1'b1; c1_req = 1'b1;
        c1_seen = 1'b0;
        cyc();
        chk("t6_c0_gnt", 32'(u_c0_gnt), 32'd1);
        base = wq.size();
        for (int i = 0; i < 16; i++) begin
            w = 0;
            while (u_c0_busy !== 1'b0 && w < 100) begin
                cyc();
                if (u_c1_gnt === 1'b1) c1_seen = 1'b1;
                w++;
            end
            chk("t6_wait_bound", 32'(w < 100), 32'd1);
            c0_we = 1'b1; c0_row = (i >= 8); c0_col = 4'(i); c0_char = 8'(8'h30 + i);
            c1_we = 1'b1; c1_char = 8'hC0;
            cyc();
            if (u_c1_gnt === 1'b1) c1_seen = 1'b1;
            c0_we = 1'b0; c1_we = 1'b0;
        end
        repeat (6) begin
            cyc();
            if (u_c1_gnt === 1'b1) c1_seen = 1'b1;
        end
        chk("t6_count", 32'(wq.size() - base), 32'd16);
        chk("t6_no_c1_gnt", 32'(c1_seen), 32'd0);
        for (int i = 0; i < 16; i++) begin
            if (base + i < wq.size()) begin
                chk("t6_order", 32'(wq[base + i]), 32'({1'(i >= 8), 4'(i), 8'(8'h30 + i)}));
            end
        end
        c0_req = 1'b0;
        w = 0;
        while (u_c1_gnt !== 1'b1 && w < 20) begin
            cyc();
            w++;
        end
        chk("t6_c1_after", 32'(u_c1_gnt), 32'd1);
        c1_req = 1'b0;
        busy_mode = 1'b0;
        repeat (4) cyc();

        // Randomized traffic, checked cycle by cycle against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(15) == 0) c0_req = ~c0_req;
            if ($urandom_range(15) == 0) c1_req = ~c1_req;
            c0_we = 1'($urandom_range(1));
            c1_we = 1'($urandom_range(1));
            c0_row = 1'($urandom); c0_col = 4'($urandom); c0_char = 8'($urandom);
            c1_row = 1'($urandom); c1_col = 4'($urandom); c1_char = 8'($urandom);
            busy_force = ($urandom_range(9) < 3);
            RST = ($urandom_range(199) == 0);
            cyc();
        end
        RST = 1'b0;
        repeat (3) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
